fpu_operand_feeder: RTL and testbench

//   Upstream feeder for the free-running FPU. Accepts operand pairs over a valid/ready handshake,

---
 rtl/fpu_operand_feeder_if.sv | 35 +++
 rtl/fpu_operand_feeder.sv | 138 +++++++++++++
 tb/tb_fpu_operand_feeder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_operand_feeder_if.sv
// Handshake and FPU-side bundle for the operand feeder.
// slave = feeder side, master = environment driving it.
interface fpu_operand_feeder_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_op_a;
   logic [31:0] in_op_b;
   logic [31:0] fpu_op_a;
   logic [31:0] fpu_op_b;
   logic [31:0] fpu_data;
   logic [3:0]  fpu_status;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_status;
   logic        busy;
   logic        status_err;
   logic [15:0] ops_done;

   modport slave (
      input  in_valid, in_op_a, in_op_b,
      input  fpu_data, fpu_status, out_ready,
      output in_ready, fpu_op_a, fpu_op_b,
      output out_valid, out_data, out_status,
      output busy, status_err, ops_done
   );

   modport master (
      output in_valid, in_op_a, in_op_b,
      output fpu_data, fpu_status, out_ready,
      input  in_ready, fpu_op_a, fpu_op_b,
      input  out_valid, out_data, out_status,
      input  busy, status_err, ops_done
   );
endinterface

// File: rtl/fpu_operand_feeder.sv
// Holds operand pairs on a free-running FPU, then
// captures result/status into a show-ahead FIFO.
module fpu_operand_feeder #(
   parameter int HOLD_CYCLES = 64,
   parameter int FIFO_DEPTH  = 4
) (
   input logic clock100KHz,
   input logic reset,
   fpu_operand_feeder_if.slave bus
);
   localparam int HW = $clog2(HOLD_CYCLES);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      CAPTURE
   } state_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  status;
   } entry_t;

   state_t        state_q, state_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [31:0]   op_a_q, op_a_d;
   logic [31:0]   op_b_q, op_b_d;
   entry_t        mem_q [FIFO_DEPTH];
   entry_t        mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          err_q, err_d;
   logic [15:0]   ops_q, ops_d;

   logic in_ready;
   logic push;
   logic pop;
   logic onehot;

   always_comb begin
      unique case (bus.fpu_status)
         4'b0001, 4'b0010,
         4'b0100, 4'b1000: onehot = 1'b1;
         default:          onehot = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      err_d      = err_q;
      ops_d      = ops_q;
      in_ready   = 1'b0;
      push       = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = count_q < CW'(FIFO_DEPTH);
            if (bus.in_valid && in_ready) begin
               op_a_d     = bus.in_op_a;
               op_b_d     = bus.in_op_b;
               hold_cnt_d = HW'(HOLD_CYCLES - 1);
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (hold_cnt_q == '0) state_d = CAPTURE;
            else hold_cnt_d = hold_cnt_q - 1'b1;
         end
         CAPTURE: begin
            push    = 1'b1;
            ops_d   = ops_q + 16'd1;
            state_d = IDLE;
            if (!onehot) err_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Push only ever follows an accept that saw a free slot.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pop      = (count_q != '0) && bus.out_ready;
      if (push) begin
         mem_d[wr_ptr_q] = '{bus.fpu_data, bus.fpu_status};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock100KHz or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
         ops_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         err_q      <= err_d;
         ops_q      <= ops_d;
         mem_q      <= mem_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.fpu_op_a   = op_a_q;
   assign bus.fpu_op_b   = op_b_q;
   assign bus.out_valid  = count_q != '0;
   assign bus.out_data   = bus.out_valid ? mem_q[rd_ptr_q].data : '0;
   assign bus.out_status = bus.out_valid ? mem_q[rd_ptr_q].status : '0;
   assign bus.busy       = state_q != IDLE;
   assign bus.status_err = err_q;
   assign bus.ops_done   = ops_q;
endmodule

// File: tb/tb_fpu_operand_feeder.sv
// Directed bench for fpu_operand_feeder with a stubbed FPU
// driven straight from the stimulus.
module tb_fpu_operand_feeder;
   logic clk;
   logic rst;
   int   checks;
   int   errs;

   fpu_operand_feeder_if bus ();

   fpu_operand_feeder #(
      .HOLD_CYCLES(64),
      .FIFO_DEPTH (4)
   ) dut (
      .clock100KHz(clk),
      .reset      (rst),
      .bus        (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_op_a  = a;
      bus.in_op_b  = b;
      while (!bus.in_ready && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) chk("accept_timeout", 32'd1, 32'd0);
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic pop_expect(input string tag, input logic [31:0] exp);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk(tag, bus.out_data, exp);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      checks         = 0;
      errs           = 0;
      rst            = 1'b1;
      bus.in_valid   = 1'b0;
      bus.in_op_a    = '0;
      bus.in_op_b    = '0;
      bus.fpu_data   = '0;
      bus.fpu_status = 4'b0001;
      bus.out_ready  = 1'b0;
      repeat (2) step();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      rst = 1'b0;
      step();
      chk("rel_ready", 32'(bus.in_ready), 32'd1);
      chk("rel_ops", 32'(bus.ops_done), 32'd0);

      // reset mid-HOLD with one result already queued
      bus.fpu_data = 32'h0000_00AA;
      accept(32'h1111_1111, 32'h2222_2222);
      wait_idle();
      chk("pre_valid", 32'(bus.out_valid), 32'd1);
      accept(32'h3333_3333, 32'h4444_4444);
      repeat (29) step();
      chk("hold_busy", 32'(bus.busy), 32'd1);
      chk("hold_opa", bus.fpu_op_a, 32'h3333_3333);
      rst = 1'b1;
      #1;
      chk("mid_opa", bus.fpu_op_a, 32'd0);
      chk("mid_opb", bus.fpu_op_b, 32'd0);
      chk("mid_busy", 32'(bus.busy), 32'd0);
      chk("mid_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_data", bus.out_data, 32'd0);
      chk("mid_stat", 32'(bus.out_status), 32'd0);
      chk("mid_ops", 32'(bus.ops_done), 32'd0);
      chk("mid_err", 32'(bus.status_err), 32'd0);
      step();
      rst = 1'b0;
      step();
      chk("post_ready", 32'(bus.in_ready), 32'd1);
      chk("post_busy", 32'(bus.busy), 32'd0);

      // single op latency
      bus.fpu_data   = 32'h4000_0000;
      bus.fpu_status = 4'b0001;
      accept(32'h3E00_0000, 32'h3E00_0000);
      chk("t2_opa", bus.fpu_op_a, 32'h3E00_0000);
      chk("t2_opb", bus.fpu_op_b, 32'h3E00_0000);
      chk("t2_ready", 32'(bus.in_ready), 32'd0);
      repeat (64) step();
      chk("t2_early", 32'(bus.out_valid), 32'd0);
      chk("t2_cap_busy", 32'(bus.busy), 32'd1);
      step();
      chk("t2_valid", 32'(bus.out_valid), 32'd1);
      chk("t2_stat", 32'(bus.out_status), 32'd1);
      chk("t2_ops", 32'(bus.ops_done), 32'd1);
      chk("t2_opa_kept", bus.fpu_op_a, 32'h3E00_0000);
      pop_expect("t2_data", 32'h4000_0000);
      chk("t2_empty", 32'(bus.out_valid), 32'd0);

      // backpressure: 4 fit, 5th waits for a pop
      for (int i = 1; i <= 4; i++) begin
         bus.fpu_data = 32'h100 + 32'(i);
         accept(32'(i), 32'(i));
         wait_idle();
      end
      chk("t3_full_ready", 32'(bus.in_ready), 32'd0);
      bus.fpu_data = 32'h105;
      bus.in_valid = 1'b1;
      bus.in_op_a  = 32'h55;
      bus.in_op_b  = 32'h66;
      repeat (3) step();
      chk("t3_stall_ready", 32'(bus.in_ready), 32'd0);
      chk("t3_stall_busy", 32'(bus.busy), 32'd0);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("t3_freed", 32'(bus.in_ready), 32'd1);
      chk("t3_head", bus.out_data, 32'h102);
      step();
      bus.in_valid = 1'b0;
      chk("t3_acc_busy", 32'(bus.busy), 32'd1);
      chk("t3_acc_opa", bus.fpu_op_a, 32'h55);
      wait_idle();
      for (int i = 2; i <= 5; i++)
         pop_expect("t3_order", 32'h100 + 32'(i));
      chk("t3_empty", 32'(bus.out_valid), 32'd0);

      // push and pop on the same edge
      bus.fpu_data = 32'h201;
      accept(32'h7, 32'h7);
      wait_idle();
      bus.fpu_data = 32'h202;
      accept(32'h8, 32'h8);
      wait_idle();
      bus.fpu_data = 32'h203;
      accept(32'h9, 32'h9);
      repeat (64) step();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("t4_busy", 32'(bus.busy), 32'd0);
      pop_expect("t4_first", 32'h202);
      pop_expect("t4_second", 32'h203);
      chk("t4_empty", 32'(bus.out_valid), 32'd0);

      // non-one-hot status is sticky
      bus.fpu_data   = 32'h301;
      bus.fpu_status = 4'b0011;
      accept(32'hA, 32'hA);
      wait_idle();
      chk("t5_stat", 32'(bus.out_status), 32'h3);
      chk("t5_err", 32'(bus.status_err), 32'd1);
      pop_expect("t5_data", 32'h301);
      bus.fpu_data   = 32'h302;
      bus.fpu_status = 4'b0010;
      accept(32'hB, 32'hB);
      wait_idle();
      chk("t5_stat2", 32'(bus.out_status), 32'h2);
      chk("t5_sticky", 32'(bus.status_err), 32'd1);
      chk("t5_ops", 32'(bus.ops_done), 32'd11);
      pop_expect("t5_data2", 32'h302);

      // ten back-to-back ops, pointers wrap
      bus.fpu_status = 4'b0100;
      bus.out_ready  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.fpu_data = 32'h400 + 32'(i);
         accept(32'(i), 32'(i));
         wait_idle();
         chk("t6_valid", 32'(bus.out_valid), 32'd1);
         chk("t6_data", bus.out_data, 32'h400 + 32'(i));
      end
      step();
      bus.out_ready = 1'b0;
      chk("t6_empty", 32'(bus.out_valid), 32'd0);
      chk("t6_ops", 32'(bus.ops_done), 32'd21);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
